// File: rtl/sonar_pkg.sv
// Shared sonar definitions: ping scheduler state encoding, timing defaults
// and a saturating counter helper.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX     = 3'd1,
        ST_GUARD  = 3'd2,
        ST_LISTEN = 3'd3,
        ST_WAIT   = 3'd4
    } ping_state_t;

    // Ring-down cycles after chirp end, before the receive window opens.
    localparam int GUARD_CYC_DEFAULT  = 16;
    // Longest time the chirp generator may take before we give up on it.
    localparam int TX_TIMEOUT_DEFAULT = 1024;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ping_scheduler.sv
// Sonar ping burst scheduler: sequences TX -> GUARD -> LISTEN -> WAIT for
// each ping of a burst, holding the ping repetition interval from TX entry.
// All outputs are registered and change on the same edge as the state.
module ping_scheduler
    import sonar_pkg::*;
#(
    parameter int GUARD_CYC  = GUARD_CYC_DEFAULT,
    parameter int TX_TIMEOUT = TX_TIMEOUT_DEFAULT
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  burst_len,
    input  logic [15:0] pri_cycles,
    input  logic [15:0] listen_cycles,
    input  logic        tx_over,
    output logic        tx_en,
    output logic        rx_gate,
    output logic [7:0]  ping_idx,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Limits clamped into the 16-bit phase counter; a zero length still
    // spends one cycle in the state.
    localparam logic [15:0] TX_LIM =
        (TX_TIMEOUT > 65535) ? 16'hFFFF : (TX_TIMEOUT < 1) ? 16'd1 : 16'(TX_TIMEOUT);
    localparam logic [15:0] GUARD_LIM =
        (GUARD_CYC > 65535) ? 16'hFFFF : (GUARD_CYC < 1) ? 16'd1 : 16'(GUARD_CYC);

    ping_state_t state;
    logic [15:0] pri_cnt;     // cycles since the current ping entered TX
    logic [15:0] phase_cnt;   // cycles spent in the current TX/GUARD/LISTEN state
    logic [7:0]  burst_q;
    logic [15:0] pri_q;
    logic [15:0] listen_q;
    logic        last_ping;

    assign last_ping = ({1'b0, ping_idx} + 9'd1) >= {1'b0, burst_q};

    // Burst sequencer with registered outputs; abort dominates every other
    // event once a burst is running, reset dominates everything.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_en     <= 1'b0;
            rx_gate   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ping_idx  <= 8'd0;
            pri_cnt   <= 16'd0;
            phase_cnt <= 16'd0;
            burst_q   <= 8'd0;
            pri_q     <= 16'd0;
            listen_q  <= 16'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != ST_IDLE)
                pri_cnt <= sat_inc16(pri_cnt);

            if (state == ST_IDLE) begin
                // start together with abort is simply not accepted
                if (start && !abort) begin
                    state     <= ST_TX;
                    tx_en     <= 1'b1;
                    busy      <= 1'b1;
                    ping_idx  <= 8'd0;
                    pri_cnt   <= 16'd1;
                    phase_cnt <= 16'd1;
                    burst_q   <= (burst_len == 8'd0) ? 8'd1 : burst_len;
                    pri_q     <= pri_cycles;
                    listen_q  <= listen_cycles;
                end
            end else if (abort) begin
                state     <= ST_IDLE;
                tx_en     <= 1'b0;
                rx_gate   <= 1'b0;
                busy      <= 1'b0;
                err       <= 1'b1;
                pri_cnt   <= 16'd0;
                phase_cnt <= 16'd0;
            end else begin
                case (state)
                    ST_TX: begin
                        if (tx_over) begin
                            state     <= ST_GUARD;
                            tx_en     <= 1'b0;
                            phase_cnt <= 16'd1;
                        end else if (phase_cnt >= TX_LIM) begin
                            state     <= ST_IDLE;
                            tx_en     <= 1'b0;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                            pri_cnt   <= 16'd0;
                            phase_cnt <= 16'd0;
                        end else begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                    ST_GUARD: begin
                        if (phase_cnt >= GUARD_LIM) begin
                            if (listen_q == 16'd0) begin
                                state     <= ST_WAIT;
                                phase_cnt <= 16'd0;
                            end else begin
                                state     <= ST_LISTEN;
                                rx_gate   <= 1'b1;
                                phase_cnt <= 16'd1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                    ST_LISTEN: begin
                        if (phase_cnt >= listen_q) begin
                            state     <= ST_WAIT;
                            rx_gate   <= 1'b0;
                            phase_cnt <= 16'd0;
                        end else begin
                            phase_cnt <= phase_cnt + 16'd1;
                        end
                    end
                    ST_WAIT: begin
                        // an already-elapsed interval leaves after one WAIT cycle
                        if (pri_cnt >= pri_q) begin
                            if (last_ping) begin
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pri_cnt <= 16'd0;
                            end else begin
                                state     <= ST_TX;
                                tx_en     <= 1'b1;
                                ping_idx  <= ping_idx + 8'd1;
                                pri_cnt   <= 16'd1;
                                phase_cnt <= 16'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        tx_en     <= 1'b0;
                        rx_gate   <= 1'b0;
                        busy      <= 1'b0;
                        pri_cnt   <= 16'd0;
                        phase_cnt <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ping_scheduler.sv
// Directed bench for ping_scheduler with a chirp generator model that
// answers tx_over 513 cycles after tx_en rises.
module tb_ping_scheduler;

    logic        clk_100 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic [15:0] pri_cycles = 16'd0;
    logic [15:0] listen_cycles = 16'd0;
    logic        tx_over;
    logic        tx_en, rx_gate, busy, done, err;
    logic [7:0]  ping_idx;

    logic        tx_over_m = 1'b0;
    logic        tx_over_tb = 1'b0;
    logic        chirp_on = 1'b1;
    logic [15:0] chirp_cnt = 16'd0;
    assign tx_over = tx_over_m | tx_over_tb;

    int tests = 0;
    int fails = 0;

    // per-run measurements
    int n_rise, rise_t[8], idx_at_rise[8];
    int rx_first, rx_last, rx_cnt, done_cnt, done_t, err_cnt, err_t;
    logic last_tx, last_rx, last_busy, last_done, last_err;
    logic [7:0] last_idx;
    logic timed_out;

    ping_scheduler dut (
        .clk_100(clk_100), .rst(rst), .start(start), .abort(abort),
        .burst_len(burst_len), .pri_cycles(pri_cycles), .listen_cycles(listen_cycles),
        .tx_en(tx_en), .tx_over(tx_over), .rx_gate(rx_gate), .ping_idx(ping_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_100 = ~clk_100;

    // chirp generator model: one-cycle tx_over on the 513th edge with tx_en high
    always @(posedge clk_100) begin
        if (tx_en && chirp_on) begin
            chirp_cnt <= chirp_cnt + 16'd1;
            tx_over_m <= (chirp_cnt == 16'd512);
        end else begin
            chirp_cnt <= 16'd0;
            tx_over_m <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk_100);
        #1;
    endtask

    // Start a burst and watch it until idle; t=0 is the first sample after
    // the accepting edge. Optional abort/restart/reset at a given sample.
    task automatic run_burst(input logic [7:0] bl, input logic [15:0] pri,
                             input logic [15:0] lis, input int budget,
                             input int abort_at, input int restart_at, input int rst_at);
        n_rise = 0; rx_first = -1; rx_last = -1; rx_cnt = 0;
        done_cnt = 0; done_t = -1; err_cnt = 0; err_t = -1; timed_out = 1'b1;
        burst_len = bl; pri_cycles = pri; listen_cycles = lis;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (tx_en && (t == 0 || !last_tx) && n_rise < 8) begin
                rise_t[n_rise] = t; idx_at_rise[n_rise] = int'(ping_idx); n_rise++;
            end
            if (rx_gate) begin
                if (rx_first < 0) rx_first = t;
                rx_last = t; rx_cnt++;
            end
            if (done) begin done_cnt++; done_t = t; end
            if (err) begin err_cnt++; err_t = t; end
            last_tx = tx_en; last_rx = rx_gate; last_busy = busy;
            last_done = done; last_err = err; last_idx = ping_idx;
            if (!busy) begin timed_out = 1'b0; break; end
            abort = (t == abort_at);
            rst = (t == rst_at);
            start = (t == restart_at);
            if (t == restart_at) begin burst_len = 8'd5; listen_cycles = 16'd0; pri_cycles = 16'd50; end
            tick();
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        tests++; if ({tx_en, rx_gate, busy, done, err} !== 5'b0) begin fails++; $display("FAIL reset_outs: got %b expected 00000", {tx_en, rx_gate, busy, done, err}); end
        tests++; if (ping_idx !== 8'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", ping_idx); end
        rst = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_burst;
        run_burst(8'd3, 16'd2000, 16'd600, 7000, -1, -1, -1);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL burst_timeout: got %b expected 0", timed_out); end
        tests++; if (n_rise !== 3) begin fails++; $display("FAIL burst_rises: got %0d expected 3", n_rise); end
        tests++; if (rise_t[1] !== 2000) begin fails++; $display("FAIL burst_rise1: got %0d expected 2000", rise_t[1]); end
        tests++; if (rise_t[2] !== 4000) begin fails++; $display("FAIL burst_rise2: got %0d expected 4000", rise_t[2]); end
        tests++; if (idx_at_rise[2] !== 2) begin fails++; $display("FAIL burst_idx2: got %0d expected 2", idx_at_rise[2]); end
        tests++; if (rx_first !== 530) begin fails++; $display("FAIL burst_rx_first: got %0d expected 530", rx_first); end
        tests++; if (rx_cnt !== 1800) begin fails++; $display("FAIL burst_rx_cnt: got %0d expected 1800", rx_cnt); end
        tests++; if (done_cnt !== 1 || done_t !== 6000) begin fails++; $display("FAIL burst_done: got cnt %0d at %0d expected 1 at 6000", done_cnt, done_t); end
        tests++; if (err_cnt !== 0) begin fails++; $display("FAIL burst_err: got %0d expected 0", err_cnt); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL burst_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_overrun;
        run_burst(8'd2, 16'd100, 16'd600, 3000, -1, -1, -1);
        tests++; if (n_rise !== 2 || rise_t[1] !== 1131) begin fails++; $display("FAIL overrun_rise: got %0d rises, 2nd at %0d expected 2 at 1131", n_rise, rise_t[1]); end
        tests++; if (rx_cnt !== 1200) begin fails++; $display("FAIL overrun_rx_cnt: got %0d expected 1200", rx_cnt); end
        tests++; if (idx_at_rise[1] !== 1) begin fails++; $display("FAIL overrun_idx: got %0d expected 1", idx_at_rise[1]); end
        tests++; if (err_cnt !== 0 || done_t !== 2262) begin fails++; $display("FAIL overrun_end: got err %0d done at %0d expected 0 and 2262", err_cnt, done_t); end
    endtask

    task automatic test_timeout;
        chirp_on = 1'b0;
        run_burst(8'd1, 16'd2000, 16'd600, 1500, -1, -1, -1);
        chirp_on = 1'b1;
        tests++; if (err_cnt !== 1 || err_t !== 1024) begin fails++; $display("FAIL timeout_err: got cnt %0d at %0d expected 1 at 1024", err_cnt, err_t); end
        tests++; if (last_busy !== 1'b0 || last_tx !== 1'b0) begin fails++; $display("FAIL timeout_idle: got busy %b tx_en %b expected 0 0", last_busy, last_tx); end
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL timeout_done: got %0d expected 0", done_cnt); end
        tick();
        tests++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL timeout_after: got err %b busy %b expected 0 0", err, busy); end
    endtask

    task automatic test_abort;
        run_burst(8'd3, 16'd2000, 16'd600, 3000, 2539, -1, -1);
        tests++; if (rx_last !== 2539) begin fails++; $display("FAIL abort_rx_last: got %0d expected 2539", rx_last); end
        tests++; if (err_cnt !== 1 || err_t !== 2540 || last_rx !== 1'b0) begin fails++; $display("FAIL abort_err: got cnt %0d at %0d rx %b expected 1 at 2540 rx 0", err_cnt, err_t, last_rx); end
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        repeat (5) tick();
        tests++; if (err !== 1'b0 || ping_idx !== 8'd1) begin fails++; $display("FAIL abort_after: got err %b idx %0d expected 0 1", err, ping_idx); end
    endtask

    task automatic test_start_busy;
        // mid-burst start with different settings must not change the burst
        run_burst(8'd1, 16'd2000, 16'd600, 3000, -1, 10, -1);
        tests++; if (n_rise !== 1 || rx_cnt !== 600) begin fails++; $display("FAIL start_busy_shape: got %0d rises %0d rx expected 1 600", n_rise, rx_cnt); end
        tests++; if (done_cnt !== 1 || done_t !== 2000) begin fails++; $display("FAIL start_busy_done: got cnt %0d at %0d expected 1 at 2000", done_cnt, done_t); end
    endtask

    task automatic test_reset_mid;
        run_burst(8'd3, 16'd2000, 16'd600, 3000, -1, -1, 2005);
        tests++; if (idx_at_rise[1] !== 1) begin fails++; $display("FAIL rst_mid_idx_before: got %0d expected 1", idx_at_rise[1]); end
        tests++; if ({last_tx, last_rx, last_busy, last_done, last_err} !== 5'b0 || last_idx !== 8'd0) begin fails++; $display("FAIL rst_mid_outs: got %b idx %0d expected 00000 idx 0", {last_tx, last_rx, last_busy, last_done, last_err}, last_idx); end
        tests++; if (done_cnt !== 0 || err_cnt !== 0) begin fails++; $display("FAIL rst_mid_pulses: got done %0d err %0d expected 0 0", done_cnt, err_cnt); end
        rst = 1'b0;
        repeat (3) tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rst_mid_after: got busy %b done %b err %b expected 0", busy, done, err); end
    endtask

    task automatic test_single_no_listen;
        run_burst(8'd0, 16'd100, 16'd0, 2000, -1, -1, -1);
        tests++; if (n_rise !== 1) begin fails++; $display("FAIL single_rises: got %0d expected 1", n_rise); end
        tests++; if (rx_cnt !== 0) begin fails++; $display("FAIL single_rx: got %0d expected 0", rx_cnt); end
        tests++; if (done_cnt !== 1 || done_t !== 531) begin fails++; $display("FAIL single_done: got cnt %0d at %0d expected 1 at 531", done_cnt, done_t); end
    endtask

    task automatic test_idle_inputs;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; tx_over_tb = 1'b1;
        tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL start_abort_idle: got busy %b err %b expected 0 0", busy, err); end
        tick();
        tx_over_tb = 1'b0;
        tick();
        tests++; if ({tx_en, rx_gate, busy, done, err} !== 5'b0) begin fails++; $display("FAIL tx_over_idle: got %b expected 00000", {tx_en, rx_gate, busy, done, err}); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_overrun();
        test_timeout();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_single_no_listen();
        test_idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ping_scheduler.md
PING_SCHEDULER -- requirements
Module: ping_scheduler

Interface
REQ-001 Parameter GUARD_CYC, default 16: ring-down cycles after chirp end, before listen.
REQ-002 Parameter TX_TIMEOUT, default 1024: max cycles in TX awaiting tx_over.
REQ-003 Port clk_100  in  1: single 100 MHz clock; all logic on rising edge.
REQ-004 Port rst  in  1: reset, synchronous, active-high.
REQ-005 Port start  in  1: one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port abort  in  1: level; terminates burst at next edge.
REQ-007 Port burst_len  in  8: pings per burst; latched on accepted start; 0 treated as 1.
REQ-008 Port pri_cycles  in  16: ping repetition interval, counted from TX entry; latched on start.
REQ-009 Port listen_cycles  in  16: receive-window length; latched on start; 0 means no LISTEN state.
REQ-010 Port tx_en  out  1: drives chirp generator enable; high only in TX.
REQ-011 Port tx_over  in  1: chirp-complete pulse from chirp generator.
REQ-012 Port rx_gate  out  1: receive-window enable; high only in LISTEN.
REQ-013 Port ping_idx  out  8: index of current ping, 0-based.
REQ-014 Port busy  out  1: high in every state except IDLE.
REQ-015 Port done  out  1: one-cycle pulse, burst completed normally.
REQ-016 Port err  out  1: one-cycle pulse, TX timeout or abort.

Function
REQ-017 FSM states SHALL be IDLE, TX, GUARD, LISTEN, WAIT; all outputs registered.
REQ-018 IDLE->TX on start; config latched same edge; ping_idx<=0; pri counter<=1.
REQ-019 TX: tx_en=1; on tx_over ->GUARD; tx_en low in first GUARD cycle.
REQ-020 TX: if TX_TIMEOUT cycles elapse without tx_over, ->IDLE with err pulse.
REQ-021 GUARD lasts exactly GUARD_CYC cycles, then ->LISTEN, or ->WAIT if listen_cycles=0.
REQ-022 LISTEN lasts exactly listen_cycles cycles with rx_gate=1, then ->WAIT.
REQ-023 The pri counter (16-bit, saturating at 0xFFFF) SHALL run from TX entry through WAIT.
REQ-024 WAIT: when pri counter >= pri_cycles, and if ping_idx+1 < burst_len, ->TX, ping_idx+1, counter<=1.
REQ-025 If PRI has already elapsed on WAIT entry, WAIT SHALL last exactly one cycle (overrun; no error).
REQ-026 WAIT with last ping complete: ->IDLE, done pulse same edge.
REQ-027 abort in any non-IDLE state: ->IDLE next edge; tx_en, rx_gate low; err pulse; no done.
REQ-028 abort together with tx_over or done condition: abort wins.
REQ-029 start while busy SHALL be ignored; start and abort together in IDLE: stay IDLE, no err.
REQ-030 tx_over outside TX SHALL be ignored.
REQ-031 Because tx_en deasserts between pings, the chirp generator restarts from address 0 each ping.

Reset
REQ-032 rst high: state IDLE; tx_en, rx_gate, busy, done, err =0; ping_idx=0; counters=0; latched config=0.
REQ-033 Reset mid-burst SHALL take effect at the next edge, overriding all inputs, with no done or err pulse.

Structure
REQ-034 The state encoding and GUARD_CYC/TX_TIMEOUT defaults SHALL be defined in shared package sonar_pkg.
REQ-035 Implementation SHALL be a single module with no sub-modules; the chirp generator is instantiated by the parent.

Verification
REQ-036 burst_len=3, pri=2000, listen=600, model chirp tx_over 513 cycles after tx_en: three tx_en rises 2000 cycles apart; rx_gate 600 cycles each; done exactly once, after third WAIT.
REQ-037 pri=100, listen=600 (overrun case): next TX entered one cycle after LISTEN ends; no err; ping_idx increments correctly.
REQ-038 tx_over held low: err pulse TX_TIMEOUT cycles after TX entry; busy low next cycle; no done.
REQ-039 abort asserted in the 10th LISTEN cycle of ping 1: rx_gate low next cycle; err=1 for one cycle; ping_idx=1 retained until next start.
REQ-040 rst asserted mid-TX, plus start pulse while busy: all outputs at reset values next cycle; start while busy produces no config change.
REQ-041 burst_len=0, listen=0: exactly one ping; GUARD goes directly to WAIT; rx_gate never asserted.
